// File: rtl/clk_div_seq_pkg.sv
// Shared types and defaults for the programmable clock-divider sequencer.
`timescale 1ns/1ps
package clk_div_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int CNT_W_DEF       = 16;
  localparam int DEFAULT_DIV_DEF = 5;

endpackage

// File: rtl/clk_div_sequencer_halfperiod_counter.sv
// Loadable half-period down-counter; holds at zero so a full-scale load never wraps.
`timescale 1ns/1ps
module halfperiod_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clk_div_sequencer.sv
// Divided clock + tick generator whose half-period is reprogrammed live,
// with new ratios applied only on period boundaries.
`timescale 1ns/1ps
module clk_div_sequencer
  import clk_div_seq_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             slower_clk,
  output logic             tick,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             sclk_q, sclk_d;
  logic             tick_q, tick_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;
  logic             boundary;
  logic             apply_pend;
  logic             accept;
  logic [CNT_W-1:0] div_eff;

  halfperiod_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = 1'b0;
    cnt_load   = 1'b0;

    // A pending ratio is promoted at a boundary and already sizes the HIGH
    // phase that starts there, so the load value sees it in the same cycle.
    boundary     = (state_q == IDLE) || ((state_q == LOW) && cnt_zero);
    apply_pend   = boundary && pend_vld_q;
    div_eff      = apply_pend ? pend_q : cur_q;
    cnt_load_val = div_eff - CNT_W'(1);

    if (apply_pend) begin
      cur_d      = pend_q;
      pend_vld_d = 1'b0;
    end

    unique case (state_q)
      IDLE: if (run) begin
        state_d  = HIGH;
        cnt_load = 1'b1;
      end
      HIGH: if (cnt_zero) begin
        state_d  = LOW;
        cnt_load = 1'b1;
      end
      LOW: if (cnt_zero) begin
        state_d  = run ? HIGH : IDLE;
        cnt_load = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // ready is a flop, so this never depends on cfg_valid combinationally
    accept = cfg_valid && ready_q;
    if (accept) begin
      if (cfg_div == '0) begin
        err_d = 1'b1;
      end else begin
        pend_d     = cfg_div;
        pend_vld_d = 1'b1;
      end
    end

    ready_d = !pend_vld_d;
    sclk_d  = (state_d == HIGH);
    tick_d  = (state_d == HIGH) && (state_q != HIGH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cur_q      <= CNT_W'(DEFAULT_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
      sclk_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      sclk_q     <= sclk_d;
      tick_q     <= tick_d;
    end
  end

  assign cfg_ready  = ready_q;
  assign cfg_err    = err_q;
  assign slower_clk = sclk_q;
  assign tick       = tick_q;
  assign busy       = pend_vld_q;

endmodule
